// File: rtl/conv_pkg.sv
// Shared definitions for the conv_v2 window / adder-tree path:
// window geometry, the packed tap bundle type and a windows-per-frame helper.
package conv_pkg;

    localparam int WIN_N    = 4;
    localparam int WIN_TAPS = WIN_N * WIN_N;
    localparam int DATA_W   = 8;

    typedef logic [WIN_TAPS-1:0][DATA_W-1:0] win_t;

    // Number of stride-aligned 4x4 windows that fit in one img_w x img_h frame.
    function automatic int win_per_frame(input int img_w, input int img_h, input int stride);
        return ((img_w - WIN_N) / stride + 1) * ((img_h - WIN_N) / stride + 1);
    endfunction

endpackage

// File: rtl/win_line_buf.sv
// One line of pixel history: single-clock RAM indexed by column.
// The read is combinational so the old pixel at a column is available in the
// same cycle that the new pixel overwrites it (read-before-write).
module win_line_buf #(
    parameter int pDATA_W = 8,
    parameter int pDEPTH  = 32,
    parameter int pADDR_W = $clog2(pDEPTH)
) (
    input  logic               iclk,
    input  logic               en,
    input  logic [pADDR_W-1:0] addr,
    input  logic [pDATA_W-1:0] wdata,
    output logic [pDATA_W-1:0] rdata
);

    logic [pDATA_W-1:0] mem [pDEPTH];

    assign rdata = mem[addr];

    // Overwrite the column slot with the newer line's pixel on every accepted pixel
    always_ff @(posedge iclk) begin
        if (en) begin
            mem[addr] <= wdata;
        end
    end

endmodule

// File: rtl/win4x4_gen.sv
// Streaming 4x4 window generator feeding the 16-input adder/average tree.
// Buffers three previous lines, shifts one 4-pixel column per accepted pixel
// into the window and emits the window when a stride-aligned position completes.
// Optional build macro WIN_STATUS_EN adds the odone port (last window of a
// frame) and a saturating frame counter.
module win4x4_gen
    import conv_pkg::*;
#(
    parameter int pDATA_W = 8,
    parameter int pIMG_W  = 32,
    parameter int pIMG_H  = 32,
    parameter int pSTRIDE = 4
) (
    input  logic                              iclk,
    input  logic                              irst_n,
    input  logic                              isof,
    input  logic                              ivalid,
    input  logic [pDATA_W-1:0]                idata,
    output logic                              ovalid,
    output logic [WIN_TAPS-1:0][pDATA_W-1:0]  odata
`ifdef WIN_STATUS_EN
    ,
    output logic                              odone
`endif
);

    localparam int CW = $clog2(pIMG_W);
    localparam int RW = $clog2(pIMG_H);

    // True when a coordinate is a legal bottom/right edge of a stride-aligned window.
    function automatic logic on_grid(input int pos);
        return (pos >= WIN_N - 1) && (((pos - (WIN_N - 1)) % pSTRIDE) == 0);
    endfunction

    logic [CW-1:0] col_p0, cur_col, col_nxt;
    logic [RW-1:0] row_p0, cur_row, row_nxt;
    logic [pDATA_W-1:0] rd0, rd1, rd2;
    logic [WIN_TAPS-1:0][pDATA_W-1:0] win_p0, win_nxt, data_p1;
    logic [WIN_N-1:0][pDATA_W-1:0] col_vec;
    logic hit, vld_p1;

    // Position of the pixel on the input this cycle; isof pins it to the frame origin
    always_comb begin
        cur_col = isof ? '0 : col_p0;
        cur_row = isof ? '0 : row_p0;
        col_nxt = cur_col + CW'(1);
        row_nxt = cur_row;
        if (cur_col == CW'(pIMG_W - 1)) begin
            col_nxt = '0;
            row_nxt = (cur_row == RW'(pIMG_H - 1)) ? '0 : cur_row + RW'(1);
        end
    end

    assign hit = ivalid && on_grid(int'(cur_col)) && on_grid(int'(cur_row));

    // Line history chain: line0 takes the new pixel, older lines take the next-newer line
    win_line_buf #(.pDATA_W(pDATA_W), .pDEPTH(pIMG_W)) u_line0 (
        .iclk(iclk), .en(ivalid), .addr(cur_col), .wdata(idata), .rdata(rd0)
    );
    win_line_buf #(.pDATA_W(pDATA_W), .pDEPTH(pIMG_W)) u_line1 (
        .iclk(iclk), .en(ivalid), .addr(cur_col), .wdata(rd0), .rdata(rd1)
    );
    win_line_buf #(.pDATA_W(pDATA_W), .pDEPTH(pIMG_W)) u_line2 (
        .iclk(iclk), .en(ivalid), .addr(cur_col), .wdata(rd1), .rdata(rd2)
    );

    // Window after this pixel: every row shifts left, newest column enters at col 3
    always_comb begin
        col_vec = {idata, rd0, rd1, rd2};
        win_nxt = win_p0;
        for (int r = 0; r < WIN_N; r++) begin
            for (int c = 0; c < WIN_N - 1; c++) begin
                win_nxt[r*WIN_N + c] = win_p0[r*WIN_N + c + 1];
            end
            win_nxt[r*WIN_N + WIN_N - 1] = col_vec[r];
        end
    end

    // ---- stage p0 -> p1: position counters and window-complete flag ----
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            col_p0 <= '0;
            row_p0 <= '0;
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= hit;
            if (ivalid) begin
                col_p0 <= col_nxt;
                row_p0 <= row_nxt;
            end
        end
    end

    // Window shift register and the held output copy of the last completed window
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            win_p0  <= '0;
            data_p1 <= '0;
        end else if (ivalid) begin
            win_p0 <= win_nxt;
            if (hit) begin
                data_p1 <= win_nxt;
            end
        end
    end

    assign ovalid = vld_p1;
    assign odata  = data_p1;

`ifdef WIN_STATUS_EN
    localparam int LAST_COL = (WIN_N - 1) + ((pIMG_W - WIN_N) / pSTRIDE) * pSTRIDE;
    localparam int LAST_ROW = (WIN_N - 1) + ((pIMG_H - WIN_N) / pSTRIDE) * pSTRIDE;

    // Count up without wrapping once the counter is full.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic        last_hit, done_p1;
    logic [15:0] frame_cnt_p1;

    assign last_hit = hit && (cur_col == CW'(LAST_COL)) && (cur_row == RW'(LAST_ROW));

    // ---- stage p0 -> p1: end-of-frame flag and debug frame counter ----
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            done_p1      <= 1'b0;
            frame_cnt_p1 <= '0;
        end else begin
            done_p1 <= last_hit;
            if (last_hit) begin
                frame_cnt_p1 <= sat_inc16(frame_cnt_p1);
            end
        end
    end

    assign odone = done_p1;
`endif

endmodule

// File: tb/tb_win4x4_gen.sv
// Bench for win4x4_gen on an 8x8 image: a stride-4 and a stride-1 instance
// share one pixel stream and are compared every cycle against an image-array
// model, plus literal expectations for the documented windows.
module tb_win4x4_gen;
    import conv_pkg::*;

    localparam int W  = 8;
    localparam int H  = 8;
    localparam int DW = 8;

    logic iclk = 1'b0;
    logic irst_n = 1'b0;
    logic isof = 1'b0;
    logic ivalid = 1'b0;
    logic [DW-1:0] idata = '0;
    logic ov4, ov1;
    win_t od4, od1;
`ifdef WIN_STATUS_EN
    logic dn4, dn1;
`endif

    always #5 iclk = ~iclk;

    win4x4_gen #(.pDATA_W(DW), .pIMG_W(W), .pIMG_H(H), .pSTRIDE(4)) u_s4 (
        .iclk(iclk), .irst_n(irst_n), .isof(isof), .ivalid(ivalid), .idata(idata),
        .ovalid(ov4), .odata(od4)
`ifdef WIN_STATUS_EN
        , .odone(dn4)
`endif
    );
    win4x4_gen #(.pDATA_W(DW), .pIMG_W(W), .pIMG_H(H), .pSTRIDE(1)) u_s1 (
        .iclk(iclk), .irst_n(irst_n), .isof(isof), .ivalid(ivalid), .idata(idata),
        .ovalid(ov1), .odata(od1)
`ifdef WIN_STATUS_EN
        , .odone(dn1)
`endif
    );

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [DW-1:0] img [H][W];
    int pos, mp, mr, mc, ms;
    logic         exp_vld  [2];
    logic         exp_done [2];
    logic [127:0] exp_dat  [2];
    int           exp_pos  [2];

    always @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            pos = 0;
            for (int k = 0; k < 2; k++) begin
                exp_vld[k]  = 1'b0;
                exp_done[k] = 1'b0;
                exp_dat[k]  = '0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                exp_vld[k]  = 1'b0;
                exp_done[k] = 1'b0;
            end
            if (ivalid) begin
                mp = isof ? 0 : pos;
                mr = mp / W;
                mc = mp % W;
                img[mr][mc] = idata;
                for (int k = 0; k < 2; k++) begin
                    ms = (k == 0) ? 4 : 1;
                    if (mr >= 3 && mc >= 3 && (mr - 3) % ms == 0 && (mc - 3) % ms == 0) begin
                        exp_vld[k] = 1'b1;
                        exp_pos[k] = mp;
                        exp_done[k] = (mr + ms > H - 1) && (mc + ms > W - 1);
                        for (int i = 0; i < 4; i++)
                            for (int j = 0; j < 4; j++)
                                exp_dat[k][(i*4+j)*8 +: 8] = img[mr-3+i][mc-3+j];
                    end
                end
                pos = (mp + 1) % (W * H);
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    int cnt [2];
    int idx4[$], idx1[$];
    logic [127:0] win4[$], win1[$];
    int done_at[$];

    always @(negedge iclk) begin
        check("s4_ovalid", 128'(ov4), 128'(exp_vld[0]));
        check("s4_odata", od4, exp_dat[0]);
        check("s1_ovalid", 128'(ov1), 128'(exp_vld[1]));
        check("s1_odata", od1, exp_dat[1]);
        if (ov4) begin
            cnt[0]++;
            idx4.push_back(exp_pos[0]);
            win4.push_back(od4);
        end
        if (ov1) begin
            cnt[1]++;
            idx1.push_back(exp_pos[1]);
            win1.push_back(od1);
        end
`ifdef WIN_STATUS_EN
        check("s4_odone", 128'(dn4), 128'(exp_done[0]));
        check("s1_odone", 128'(dn1), 128'(exp_done[1]));
        if (dn4) done_at.push_back(cnt[0]);
`endif
    end

    function automatic int idx4_at(input int i);
        return (i < idx4.size()) ? idx4[i] : -1;
    endfunction
    function automatic logic [127:0] win4_at(input int i);
        return (i < win4.size()) ? win4[i] : '1;
    endfunction

    // ---------------- stimulus ----------------
    task automatic pix(input logic v, input logic s, input logic [DW-1:0] d);
        @(posedge iclk);
        #2;
        ivalid = v;
        isof   = s;
        idata  = d;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) pix(1'b0, 1'($urandom_range(1)), DW'($urandom));
    endtask

    task automatic frame(input int n, input int gap, input bit sof, input bit rnd);
        for (int p = 0; p < n; p++) begin
            while ($urandom_range(99) < gap) pix(1'b0, 1'($urandom_range(1)), DW'($urandom));
            pix(1'b1, sof && (p == 0), rnd ? DW'($urandom) : DW'(p));
        end
    endtask

    task automatic clear_logs();
        cnt[0] = 0;
        cnt[1] = 0;
        idx4.delete();
        idx1.delete();
        win4.delete();
        win1.delete();
        done_at.delete();
    endtask

    task automatic check_case1_like(input string tag, input logic [127:0] ref_win [4]);
        check({tag, "_cnt4"}, 128'(cnt[0]), 128'(4));
        check({tag, "_idx0"}, 128'(idx4_at(0)), 128'(27));
        check({tag, "_idx1"}, 128'(idx4_at(1)), 128'(31));
        check({tag, "_idx2"}, 128'(idx4_at(2)), 128'(59));
        check({tag, "_idx3"}, 128'(idx4_at(3)), 128'(63));
        for (int i = 0; i < 4; i++) check({tag, "_win"}, win4_at(i), ref_win[i]);
    endtask

    logic [127:0] c1win [4];
    logic [127:0] w;
    int sum, gold, found;

    initial begin
        clear_logs();
        repeat (3) @(posedge iclk);
        #2;
        check("rst_ovalid4", 128'(ov4), 128'(0));
        check("rst_odata4", od4, 128'(0));
        check("rst_ovalid1", 128'(ov1), 128'(0));
        check("rst_odata1", od1, 128'(0));
        irst_n = 1'b1;

        // Case 1: stride 4, continuous, ramp pixels
        clear_logs();
        frame(64, 0, 1'b1, 1'b0);
        idle(3);
        w = win4_at(0);
        check("c1_tap0", 128'(w[7:0]), 128'(0));
        check("c1_tap3", 128'(w[31:24]), 128'(3));
        check("c1_tap12", 128'(w[103:96]), 128'(24));
        check("c1_tap15", 128'(w[127:120]), 128'(27));
        for (int i = 0; i < 4; i++) c1win[i] = win4_at(i);
        check_case1_like("c1", c1win);

        // Case 2: stride 1, continuous
        clear_logs();
        frame(64, 0, 1'b1, 1'b0);
        idle(3);
        check("c2_cnt1", 128'(cnt[1]), 128'(25));
        found = -1;
        foreach (idx1[i]) if (idx1[i] == 4*W + 5) found = i;
        w = (found >= 0) ? win1[found] : '1;
        check("c2_tap0", 128'(w[7:0]), 128'(10));
        check("c2_tap15", 128'(w[127:120]), 128'(37));
        sum = 0;
        for (int t = 0; t < 16; t++) sum += int'(w[t*8 +: 8]);
        gold = 0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) gold += (4 - 3 + i) * W + (5 - 3 + j);
        check("c2_sum", 128'(sum), 128'(gold));
        check("c2_sum_lit", 128'(sum), 128'(376));

        // Case 3: stride 4 with ~30% idle cycles (isof noise while idle)
        clear_logs();
        frame(64, 30, 1'b1, 1'b0);
        idle(3);
        check_case1_like("c3", c1win);

        // Case 4: asynchronous reset at pixel 40, then a fresh frame
        clear_logs();
        frame(41, 0, 1'b1, 1'b1);
        @(posedge iclk);
        #3;
        irst_n = 1'b0;
        ivalid = 1'b0;
        isof   = 1'b0;
        #1;
        check("c4_async_ovalid4", 128'(ov4), 128'(0));
        check("c4_async_odata4", od4, 128'(0));
        check("c4_async_odata1", od1, 128'(0));
        repeat (2) @(posedge iclk);
        #2;
        irst_n = 1'b1;
        clear_logs();
        frame(64, 0, 1'b1, 1'b0);
        idle(3);
        check_case1_like("c4", c1win);

        // Case 5: isof reasserted at pixel 20 of a random-data frame
        clear_logs();
        frame(20, 0, 1'b1, 1'b1);
        frame(64, 0, 1'b1, 1'b0);
        idle(3);
        check_case1_like("c5", c1win);

`ifdef WIN_STATUS_EN
        // Case 6: two back-to-back frames, end-of-frame pulses
        clear_logs();
        frame(64, 0, 1'b1, 1'b0);
        frame(64, 0, 1'b1, 1'b0);
        idle(3);
        check("c6_done_n", 128'(done_at.size()), 128'(2));
        check("c6_done_a", 128'((done_at.size() > 0) ? done_at[0] : -1), 128'(4));
        check("c6_done_b", 128'((done_at.size() > 1) ? done_at[1] : -1), 128'(8));
`endif

        // Random data, random gaps, three frames wrapping without isof
        clear_logs();
        frame(3 * W * H, 25, 1'b1, 1'b1);
        idle(3);
        check("rnd_cnt4", 128'(cnt[0]), 128'(3 * win_per_frame(W, H, 4)));
        check("rnd_cnt1", 128'(cnt[1]), 128'(3 * win_per_frame(W, H, 1)));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected test end");
        $fatal(1, "watchdog");
    end

endmodule
